// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit time-multiplexed scan controller with a
// double-buffered display word that commits only on the 7->0 frame wrap.
module seg_scan_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  en_in,
    output logic [3:0]  num,
    output logic [2:0]  sel,
    output logic        digit_on,
    output logic        pending,
    output logic        load_ack,
    output logic        frame_start
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;
    logic [31:0]   act_data, shd_data, nxt_data;
    logic [7:0]    act_en, shd_en, nxt_en;
    logic [2:0]    nxt_sel;
    logic          adv, wrap, commit;

    // num/digit_on are looked up from next-state values so they never lag sel
    always_comb begin
        adv      = cnt == CW'(TICK_DIV - 1);
        nxt_sel  = adv ? sel + 3'd1 : sel;
        wrap     = adv && sel == 3'd7;
        commit   = wrap && (pending || load);
        nxt_data = !commit ? act_data : load ? data_in : shd_data;
        nxt_en   = !commit ? act_en : load ? en_in : shd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sel         <= '0;
            num         <= '0;
            digit_on    <= 1'b0;
            act_data    <= '0;
            act_en      <= '0;
            shd_data    <= '0;
            shd_en      <= '0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= adv ? '0 : cnt + 1'b1;
            sel         <= nxt_sel;
            act_data    <= nxt_data;
            act_en      <= nxt_en;
            num         <= nxt_data[4*nxt_sel +: 4];
            digit_on    <= nxt_en[nxt_sel];
            // a load on the wrap edge bypasses the shadow entirely
            if (load && !wrap) begin
                shd_data <= data_in;
                shd_en   <= en_in;
            end
            pending     <= !wrap && (pending || load);
            load_ack    <= commit;
            frame_start <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, buffered commit and reset.
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  en_in = '0;
    logic [3:0]  num;
    logic [2:0]  sel;
    logic        digit_on, pending, load_ack, frame_start;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int acks;

    seg_scan_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en_in(en_in),
        .num(num), .sel(sel), .digit_on(digit_on), .pending(pending),
        .load_ack(load_ack), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got %h exp %h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    logic [3:0] t3 [8] = '{4'h1, 4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};

    initial begin
        step();
        step();
        chk("rst_sel", sel, 0);
        chk("rst_num", num, 0);
        chk("rst_on", digit_on, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ack", load_ack, 0);
        chk("rst_fs", frame_start, 0);
        rst = 1'b0;
        n = 0;

        // 1: idle scan, 4 cycles per slot, frame_start on each wrap
        for (int i = 0; i < 33; i++) begin
            step();
            chk("t1_sel", sel, (n / 4) % 8);
            chk("t1_fs", frame_start, (n % 32 == 0) ? 1 : 0);
            chk("t1_num", num, 0);
            chk("t1_on", digit_on, 0);
            chk("t1_ack", load_ack, 0);
        end

        // 2: load mid-frame at sel=3
        run_to(44);
        chk("t2_sel3", sel, 3);
        load = 1'b1; data_in = 32'h7654_3210; en_in = 8'hFF;
        step();
        load = 1'b0;
        chk("t2_pend", pending, 1);
        chk("t2_on_blank", digit_on, 0);
        run_to(63);
        chk("t2_on7_blank", digit_on, 0);
        chk("t2_pend_hold", pending, 1);
        step();
        chk("t2_ack", load_ack, 1);
        chk("t2_fs", frame_start, 1);
        chk("t2_sel", sel, 0);
        chk("t2_num", num, 0);
        chk("t2_on", digit_on, 1);
        chk("t2_pend0", pending, 0);
        step();
        chk("t2_ack_pulse", load_ack, 0);
        chk("t2_fs_pulse", frame_start, 0);
        for (int k = 0; k < 8; k++) begin
            run_to(64 + 4 * k + 2);
            chk("t2_slot_sel", sel, k);
            chk("t2_slot_num", num, k);
            chk("t2_slot_on", digit_on, 1);
        end

        // 3: two loads in one frame, latest wins, single ack
        run_to(97);
        acks = 0;
        load = 1'b1; data_in = 32'h1111_1111; en_in = 8'hFF;
        step();
        load = 1'b0;
        while (n < 100) begin acks += load_ack; step(); end
        load = 1'b1; data_in = 32'hABCD_EF01;
        step();
        load = 1'b0;
        while (n < 159) begin
            acks += load_ack;
            if (n >= 128 && (n - 128) % 4 == 1) begin
                chk("t3_num", num, t3[(n - 128) / 4]);
                chk("t3_sel", sel, (n - 128) / 4);
            end
            step();
        end
        acks += load_ack;
        chk("t3_acks", acks, 1);

        // 4: load exactly on the wrap edge with nothing pending
        chk("t4_pend_pre", pending, 0);
        load = 1'b1; data_in = 32'h0000_00C5; en_in = 8'h03;
        step();
        load = 1'b0;
        chk("t4_sel", sel, 0);
        chk("t4_num", num, 5);
        chk("t4_on", digit_on, 1);
        chk("t4_ack", load_ack, 1);
        chk("t4_pend", pending, 0);
        step();
        chk("t4_pend_after", pending, 0);
        run_to(164);
        chk("t4_sel1", sel, 1);
        chk("t4_num1", num, 4'hC);
        chk("t4_on1", digit_on, 1);
        run_to(168);
        chk("t4_on2", digit_on, 0);

        // 5: partial enables
        run_to(170);
        load = 1'b1; data_in = 32'h8888_8888; en_in = 8'h0F;
        step();
        load = 1'b0;
        run_to(192);
        chk("t5_ack", load_ack, 1);
        for (int k = 0; k < 8; k++) begin
            run_to(192 + 4 * k + 1);
            chk("t5_num", num, 8);
            chk("t5_on", digit_on, (k < 4) ? 1 : 0);
        end

        // 6: reset with pending set at sel=5, load coinciding with rst
        run_to(230);
        load = 1'b1; data_in = 32'hFFFF_FFFF; en_in = 8'hFF;
        step();
        load = 1'b0;
        chk("t6_pend", pending, 1);
        run_to(245);
        chk("t6_sel5", sel, 5);
        rst = 1'b1; load = 1'b1;
        step();
        rst = 1'b0; load = 1'b0;
        n = 0;
        chk("t6_sel", sel, 0);
        chk("t6_num", num, 0);
        chk("t6_pend0", pending, 0);
        chk("t6_on", digit_on, 0);
        acks = 0;
        for (int i = 0; i < 34; i++) begin
            step();
            acks += load_ack;
            chk("t6_on_blank", digit_on, 0);
            chk("t6_pend_idle", pending, 0);
        end
        chk("t6_acks", acks, 0);
        chk("t6_sel_end", sel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
